// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
`timescale 1ns/1ps
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Number of PC low bits that must be zero for a legal instruction address.
    function automatic int unsigned align_bits(input int unsigned inc_bytes);
        return $clog2(inc_bytes);
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational sequential-successor adder: sum = a + INC_BYTES, wrapping at XLEN bits.
`timescale 1ns/1ps
module pc_incrementer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned INC_BYTES = 4
) (
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] sum
);

    assign sum = a + XLEN'(INC_BYTES);

endmodule

// File: rtl/pc_gen_unit.sv
// PC register with sequential/redirect/trap target selection, fetch handshake and
// misaligned-redirect detection.
`timescale 1ns/1ps
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned     INC_BYTES    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            misalign_err,
    output logic [XLEN-1:0] fault_addr,
    output state_t          state
);

    localparam int unsigned     ALIGN_BITS = align_bits(INC_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    // Handshake: a request is transferred on a rising edge where fetch_valid and
    // fetch_ready are both high; pc stays stable while a request is pending,
    // except that a trap or redirect may replace it.

    state_t          next_state;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] next_fault_addr;
    logic            next_misalign_err;
    logic            target_misaligned;
    logic [XLEN-1:0] trap_pc;

    pc_incrementer #(
        .XLEN      (XLEN),
        .INC_BYTES (INC_BYTES)
    ) u_incrementer (
        .a   (pc),
        .sum (pc_plus)
    );

    assign fetch_valid       = (state == RUN);
    assign target_misaligned = |(redirect_target & ALIGN_MASK);
    assign trap_pc           = trap_vector & ~ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            fault_addr   <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            fault_addr   <= next_fault_addr;
            misalign_err <= next_misalign_err;
        end
    end

    always_comb begin
        next_state        = state;
        next_pc           = pc;
        next_fault_addr   = fault_addr;
        next_misalign_err = 1'b0;
        case (state)
            BOOT, RUN: begin
                next_state = RUN;
                // Flushes (trap, then redirect) take precedence over stall.
                if (trap_valid) begin
                    next_pc = trap_pc;
                end else if (redirect_valid && !target_misaligned) begin
                    next_pc = redirect_target;
                end else if (redirect_valid) begin
                    next_fault_addr   = redirect_target;
                    next_misalign_err = 1'b1;
                    next_state        = FAULT;
                end else if (fetch_valid && fetch_ready && !stall) begin
                    next_pc = pc_plus;
                end
            end
            FAULT: begin
                if (trap_valid) begin
                    next_pc    = trap_pc;
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
                next_pc    = RESET_VECTOR;
            end
        endcase
    end

endmodule
